regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- 32 x 32-bit general-purpose register file with two combinational read ports and one synchronous write port.
- Adds a per-register busy scoreboard. A register is marked pending when an instruction that writes it is issued, and cleared when that write retires.
- Sits between ID (reads, issue) and WB (write). Per-operand busy flags feed the stall logic, which drives the pipeline-register enables.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads return stored value only.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- rd_addr1  in  ADDR_W  read port 1 index (rs).
- rd_addr2  in  ADDR_W  read port 2 index (rt).
- rd_data1  out  DATA_W  read port 1 data.
- rd_data2  out  DATA_W  read port 2 data.
- busy1  out  1  register at rd_addr1 has an outstanding write.
- busy2  out  1  register at rd_addr2 has an outstanding write.
- wr_en  in  1  WB write strobe.
- wr_addr  in  ADDR_W  WB destination index.
- wr_data  in  DATA_W  WB data.
- issue_en  in  1  ID issues an instruction that will write issue_dst.
- issue_dst  in  ADDR_W  destination index of the issued instruction.
- busy_vec  out  2**ADDR_W  full scoreboard, for debug and the hazard unit.

Behaviour:
- Reset: with rst high at a clk edge, all registers become 0 and all busy bits become 0. rst has priority over wr_en and issue_en. Reset in mid-operation discards all pending state at that edge.
- Register 0:
  - Reads always return 0.
  - busy for index 0 is always 0.
  - Writes to index 0 are ignored.
  - Issues to index 0 are ignored.
  - busy_vec[0] is constant 0.
- Write: at a clk edge with wr_en=1 and wr_addr!=0, mem[wr_addr] <= wr_data. Latency is one edge.
- Read: combinational from rd_addr to rd_data. No clock latency.
- Bypass (BYPASS=1): if wr_en=1, wr_addr==rd_addrN and rd_addrN!=0, then rd_dataN = wr_data in the same cycle. With BYPASS=0, rd_dataN shows the old value until the edge.
- Busy set: at an edge with issue_en=1 and issue_dst!=0, busy[issue_dst] <= 1.
- Busy clear: at an edge with wr_en=1 and wr_addr!=0, busy[wr_addr] <= 0.
- Same index set and clear at the same edge: set wins, so the register stays busy. The newer producer is outstanding.
- Busy output:
  - busyN = busy[rd_addrN] AND NOT (BYPASS && wr_en && wr_addr==rd_addrN).
  - A retiring write therefore unblocks its reader in the same cycle when bypass is on.
  - An issue in the current cycle does not affect busyN until after the edge.
- Writes without a matching busy bit are legal: the data is written and the busy bit stays 0.
- Re-issuing to an already busy index is legal: the bit stays 1. There is no counter; the first write clears it.
- Both read ports may address the same index; both see identical data and busy.

Decomposition:
- Shared package regfile_pkg holds:
  - constants REG_ZERO = 0, NUM_REGS = 32, DATA_W, ADDR_W;
  - a reg_idx_t typedef.
- One natural sub-module, regfile_read_port, used twice: address decode, zero force, bypass mux and busy masking.
- Storage and the scoreboard stay in the top level.

Test Plan:
- Reset: write mem[5]=0xDEADBEEF, then assert rst for one edge. Required: rd_addr1=5 reads 0x00000000 and busy_vec == 0.
- Write/read with BYPASS=1: wr_en=1, wr_addr=3, wr_data=0x12345678, rd_addr1=3 in the same cycle. Required: rd_data1=0x12345678 before the edge, and still after the edge with wr_en=0. With BYPASS=0 the same stimulus reads 0 before the edge.
- Register 0: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF, plus issue_en=1, issue_dst=0. Required: rd_data1=0 and busy1=0 at rd_addr1=0 in all cycles.
- Scoreboard lifecycle: issue_dst=7 at edge N. Required:
  - busy1=1 (rd_addr1=7) from N+1;
  - at the WB cycle with wr_en=1, wr_addr=7, busy1=0 combinationally (BYPASS=1);
  - busy_vec[7]=0 after that edge.
- Simultaneous set/clear: busy[9]=1, then issue_en=1, issue_dst=9 with wr_en=1, wr_addr=9, wr_data=0xA5A5A5A5 at one edge. Required: mem[9]=0xA5A5A5A5 and busy_vec[9]=1 after the edge.
- Reset mid-operation: busy bits for 4, 10 and 31 set, then rst=1 together with wr_en=1, wr_addr=4, wr_data=0x1. Required: after the edge rd_data(4)=0 and busy_vec == 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the register file scoreboard
package regfile_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int REG_ZERO = 0;

    typedef logic [ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one read port: zero force, WB bypass and busy masking
module regfile_read_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] stored_data,
    input  logic              stored_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);
    import regfile_pkg::REG_ZERO;

    logic addr_zero;
    logic wb_hit;

    assign addr_zero = (rd_addr == ADDR_W'(REG_ZERO));
    // A retiring write to this index both forwards its data and releases the stall.
    assign wb_hit    = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);

    always_comb begin
        rd_data = stored_data;
        if (addr_zero) begin
            rd_data = '0;
        end else if (wb_hit) begin
            rd_data = wr_data;
        end
    end

    assign busy = !addr_zero && stored_busy && !wb_hit;
endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 32x32 register file with per-register pending-write scoreboard
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      rd_addr1,
    input  logic [ADDR_W-1:0]      rd_addr2,
    output logic [DATA_W-1:0]      rd_data1,
    output logic [DATA_W-1:0]      rd_data2,
    output logic                   busy1,
    output logic                   busy2,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   issue_en,
    input  logic [ADDR_W-1:0]      issue_dst,
    output logic [2**ADDR_W-1:0]   busy_vec
);
    import regfile_pkg::REG_ZERO;

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_next;
    logic              wr_live;
    logic              issue_live;

    assign wr_live    = wr_en && (wr_addr != ADDR_W'(REG_ZERO));
    assign issue_live = issue_en && (issue_dst != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_live) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Issue is applied after retire so a same-edge re-issue keeps the register pending.
    always_comb begin
        busy_next = busy_q;
        if (wr_live) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (issue_live) begin
            busy_next[issue_dst] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy_vec = {busy_q[DEPTH-1:1], 1'b0};

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port1 (
        .rd_addr     (rd_addr1),
        .stored_data (mem[rd_addr1]),
        .stored_busy (busy_q[rd_addr1]),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_data     (rd_data1),
        .busy        (busy1)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port2 (
        .rd_addr     (rd_addr2),
        .stored_data (mem[rd_addr2]),
        .stored_busy (busy_q[rd_addr2]),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_data     (rd_data2),
        .busy        (busy2)
    );
endmodule
